// File: rtl/display_pkg.sv
// Shared widths, limits and types for the multiplexed BCD display scanner.
// The slot state names the guard and drive parts of a digit slot.
package display_pkg;

    localparam int BCD_W      = 4;
    localparam int DIGITS_DEF = 4;

    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef logic [DIGITS_DEF*BCD_W-1:0] digits_t;

    typedef enum logic {
        SLOT_GUARD = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_state_t;

    function automatic logic bcd_ok(input logic [BCD_W-1:0] nib);
        return nib <= BCD_MAX;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_slot_timer.sv
// Slot prescaler and digit index for the display scan, with frame-start and
// transfer-edge strobes. Counters hold until the first edge after reset.
module slot_timer
    import display_pkg::*;
#(
    parameter  int DIGITS   = DIGITS_DEF,
    parameter  int PRESCALE = 1000,
    localparam int CW       = $clog2(PRESCALE),
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          run_o,
    output slot_state_t   slot_o,
    output logic [IW-1:0] idx_o,
    output logic          frame_o,
    output logic          xfer_o
);

    logic          run_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          last_cnt, last_idx;

    assign last_cnt = (cnt_q == CW'(PRESCALE - 1));
    assign last_idx = (idx_q == IW'(DIGITS - 1));

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (run_q) begin
            if (last_cnt) begin
                cnt_d = '0;
                idx_d = last_idx ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            run_q <= 1'b1;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign run_o   = run_q;
    assign slot_o  = (cnt_q == '0) ? SLOT_GUARD : SLOT_DRIVE;
    assign idx_o   = idx_q;
    assign frame_o = run_q && (cnt_q == '0) && (idx_q == '0);
    assign xfer_o  = run_q && last_cnt && last_idx;

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scanner feeding one shared BCD decoder: double-buffered
// digits, frame-synchronous transfer, leading-zero blanking and blink.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIGITS       = DIGITS_DEF,
    parameter int PRESCALE     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [DIGITS*BCD_W-1:0] digits_i,
    input  logic                    blank_lz_i,
    input  logic                    blink_i,
    output logic [BCD_W-1:0]        bcd_o,
    output logic [DIGITS-1:0]       digit_en_o,
    output logic                    frame_o,
    output logic                    load_ack_o,
    output logic                    pending_o
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIGITS*BCD_W-1:0] shadow_q, shadow_d, active_q, active_d;
    logic                    pending_q, pending_d, ack_q, ack_d;
    logic                    blz_q;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic                    phase_q, phase_d;

    logic          run, xfer;
    slot_state_t   slot;
    logic [IW-1:0] idx;

    slot_timer #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) u_slot_timer (
        .clk     (clk),
        .rst     (rst),
        .run_o   (run),
        .slot_o  (slot),
        .idx_o   (idx),
        .frame_o (frame_o),
        .xfer_o  (xfer)
    );

    // A load coinciding with the transfer edge bypasses the shadow (newest wins).
    always_comb begin
        shadow_d  = load_i ? digits_i : shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        if (xfer && (load_i || pending_q)) begin
            active_d  = load_i ? digits_i : shadow_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end else if (load_i) begin
            pending_d = 1'b1;
        end

        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (!blink_i) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (xfer) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            blz_q     <= 1'b0;
            bcnt_q    <= '0;
            phase_q   <= 1'b1;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            blz_q     <= blank_lz_i;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
        end
    end

    logic [BCD_W-1:0] nib;
    logic             upper_zero, dark;

    assign nib = active_q[idx*BCD_W +: BCD_W];

    // Digit k is a leading zero when it and every digit to its left are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(idx)) begin
                upper_zero = upper_zero & (active_q[k*BCD_W +: BCD_W] == '0);
            end
        end
        dark = !bcd_ok(nib) || (blz_q && (idx != '0) && upper_zero) || !phase_q;

        bcd_o      = bcd_ok(nib) ? nib : '0;
        digit_en_o = '0;
        if (run && (slot == SLOT_DRIVE) && !dark) begin
            digit_en_o[idx] = 1'b1;
        end
    end

    assign load_ack_o = ack_q;
    assign pending_o  = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized and directed checks of display_scan_ctrl against a cycle-count
// reference model (PRESCALE=4, DIGITS=4, BLINK_FRAMES=2).
module tb_display_scan_ctrl;

    localparam int P  = 4;
    localparam int D  = 4;
    localparam int BF = 2;
    localparam int FR = P * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_i = 1'b0;
    logic [15:0] digits_i = '0;
    logic        blank_lz_i = 1'b0;
    logic        blink_i = 1'b0;
    logic [3:0]  bcd_o;
    logic [3:0]  digit_en_o;
    logic        frame_o, load_ack_o, pending_o;

    int checks = 0;
    int errors = 0;

    display_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_i),
        .digits_i   (digits_i),
        .blank_lz_i (blank_lz_i),
        .blink_i    (blink_i),
        .bcd_o      (bcd_o),
        .digit_en_o (digit_en_o),
        .frame_o    (frame_o),
        .load_ack_o (load_ack_o),
        .pending_o  (pending_o)
    );

    always #5 clk = ~clk;

    // Reference model: time since scan start, shown value, shadow and blink frames.
    bit m_run, m_pend, m_ack, m_blz;
    int m_t, m_val, m_shadow, m_bends;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_t = 0; m_val = 0; m_shadow = 0;
            m_pend = 0; m_ack = 0; m_blz = 0; m_bends = 0;
        end else begin
            bit fend;
            fend  = m_run && (m_t % FR == FR - 1);
            m_ack = 0;
            if (load_i) m_shadow = int'(digits_i);
            if (fend && (load_i || m_pend)) begin
                m_val  = m_shadow;
                m_pend = 0;
                m_ack  = 1;
            end else if (load_i) begin
                m_pend = 1;
            end
            if (!blink_i) m_bends = 0;
            else if (fend) m_bends++;
            m_blz = blank_lz_i;
            if (!m_run) begin
                m_run = 1;
                m_t   = 0;
            end else begin
                m_t++;
            end
        end
    end

    function automatic logic [10:0] exp_vec();
        int slot, nib, upper;
        logic dark, lit;
        logic [3:0] en, bcd;
        slot  = (m_t / P) % D;
        upper = m_val >> (4 * slot);
        nib   = upper & 15;
        lit   = ((m_bends / BF) % 2) == 0;
        dark  = (nib > 9) || (m_blz && slot != 0 && upper == 0) || !lit;
        bcd   = (nib > 9) ? 4'd0 : 4'(nib);
        en    = (m_run && (m_t % P) != 0 && !dark) ? 4'(1 << slot) : 4'b0;
        return {bcd, en, m_run && (m_t % FR == 0), m_ack, m_pend};
    endfunction

    function automatic logic [10:0] obs_vec();
        return {bcd_o, digit_en_o, frame_o, load_ack_o, pending_o};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== 11'd0) begin
                errors++;
                $display("FAIL reset_state got %h exp 000", obs_vec());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] tab [16] = '{0,1,1,1, 0,2,2,2, 0,4,4,4, 0,8,8,8};
        int frames = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            frames += int'(frame_o);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL scan t=%0d got %h exp %h", m_t, obs_vec(), exp_vec());
            end
            if (i < 16) begin
                checks++;
                if (digit_en_o !== tab[i] || bcd_o !== 4'd0) begin
                    errors++;
                    $display("FAIL scan_table i=%0d got en=%b bcd=%0d exp en=%b bcd=0", i, digit_en_o, bcd_o, tab[i]);
                end
            end
        end
        checks++;
        if (frames != 3) begin
            errors++;
            $display("FAIL frame_count got %0d exp 3", frames);
        end
    endtask

    task automatic test_midframe_load();
        int acks = 0;
        int budget = 0;
        blank_lz_i = 1'b1;
        do begin
            @(negedge clk);
            budget++;
        end while (!(((m_t / P) % D == 1) && (m_t % P == 1)) && budget < 40);
        checks++;
        if (budget >= 40) begin
            errors++;
            $display("FAIL midframe_wait got timeout exp slot1");
        end
        load_i = 1'b1; digits_i = 16'h0130;
        @(negedge clk);
        load_i = 1'b0;
        checks++;
        if (pending_o !== 1'b1 || load_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL midframe_pending got p=%b a=%b exp p=1 a=0", pending_o, load_ack_o);
        end
        for (int i = 0; i < 40; i++) begin
            acks += int'(load_ack_o);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midframe t=%0d got %h exp %h", m_t, obs_vec(), exp_vec());
            end
            if (digit_en_o[3] === 1'b1 && m_val == 16'h0130) begin
                errors++;
                $display("FAIL lz_digit3 got lit exp dark");
            end
            @(negedge clk);
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL midframe_ack_count got %0d exp 1", acks);
        end
    endtask

    task automatic test_invalid();
        blank_lz_i = 1'b0;
        load_i = 1'b1; digits_i = 16'h00A5;
        @(negedge clk);
        load_i = 1'b0;
        for (int i = 0; i < 2 * FR + 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL invalid t=%0d got %h exp %h", m_t, obs_vec(), exp_vec());
            end
            if (m_val == 16'h00A5 && (m_t / P) % D == 1 && (bcd_o !== 4'd0 || digit_en_o !== 4'd0)) begin
                errors++;
                $display("FAIL invalid_slot1 got bcd=%0d en=%b exp bcd=0 en=0000", bcd_o, digit_en_o);
            end
        end
    endtask

    task automatic test_blink();
        int dark_cycles = 0;
        blink_i = 1'b1;
        for (int i = 0; i < 5 * FR; i++) begin
            @(negedge clk);
            if (m_t % P != 0 && (m_t / P) % D != 1 && digit_en_o === 4'd0) dark_cycles++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL blink t=%0d got %h exp %h", m_t, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (dark_cycles < 2 * 3 * (P - 1)) begin
            errors++;
            $display("FAIL blink_dark_cycles got %0d exp >=%0d", dark_cycles, 2 * 3 * (P - 1));
        end
        blink_i = 1'b0;
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL blink_off t=%0d got %h exp %h", m_t, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_xfer_edge();
        int acks = 0;
        int budget = 0;
        while (m_t % FR != 2 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        load_i = 1'b1; digits_i = 16'h0999;
        @(negedge clk);
        load_i = 1'b0;
        while (m_t % FR != FR - 1 && budget < 80) begin
            acks += int'(load_ack_o);
            @(negedge clk);
            budget++;
        end
        checks++;
        if (budget >= 80 || pending_o !== 1'b1) begin
            errors++;
            $display("FAIL xfer_setup got budget=%0d p=%b exp p=1", budget, pending_o);
        end
        load_i = 1'b1; digits_i = 16'h1234;
        for (int i = 0; i < FR + 2; i++) begin
            @(negedge clk);
            load_i = 1'b0;
            acks += int'(load_ack_o);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL xfer t=%0d got %h exp %h", m_t, obs_vec(), exp_vec());
            end
            if ((m_t % P) != 0 && digit_en_o !== 4'(1 << ((m_t / P) % D))) begin
                errors++;
                $display("FAIL xfer_lit got en=%b exp one-hot slot", digit_en_o);
            end
            if (i == 1 && bcd_o !== 4'd4) begin
                errors++;
                $display("FAIL xfer_digit0 got %0d exp 4", bcd_o);
            end
        end
        checks++;
        if (acks != 1 || pending_o !== 1'b0) begin
            errors++;
            $display("FAIL xfer_ack got acks=%0d p=%b exp acks=1 p=0", acks, pending_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random t=%0d got %h exp %h", m_t, obs_vec(), exp_vec());
            end
            load_i = ($urandom_range(0, 11) == 0);
            digits_i = 16'($urandom);
            if ($urandom_range(0, 3) != 0) digits_i = 16'($urandom_range(0, 9) | ($urandom_range(0, 5) << 4) | ($urandom_range(0, 1) << 8));
            if ($urandom_range(0, 40) == 0) blank_lz_i = ~blank_lz_i;
            if ($urandom_range(0, 90) == 0) blink_i = ~blink_i;
        end
        load_i = 1'b0; blink_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int budget = 0;
        load_i = 1'b1; digits_i = 16'h0456;
        @(negedge clk);
        load_i = 1'b0;
        while (!((m_t / P) % D == 2 && m_t % P == 1) && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (obs_vec() !== 11'd0 || budget >= 40) begin
            errors++;
            $display("FAIL reset_mid got %h budget=%0d exp 000", obs_vec(), budget);
        end
        for (int i = 0; i < 2 * FR; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_restart t=%0d got %h exp %h", m_t, obs_vec(), exp_vec());
            end
            if (i == 0 && (frame_o !== 1'b1 || bcd_o !== 4'd0 || pending_o !== 1'b0)) begin
                errors++;
                $display("FAIL reset_first got f=%b bcd=%0d p=%b exp f=1 bcd=0 p=0", frame_o, bcd_o, pending_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_load();
        test_invalid();
        test_blink();
        test_xfer_edge();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
